// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// ALUOp codes and datapath mux selects used by control, datapath and ALU control.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_UPPER    = 4'd10,
    ST_ERROR    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALUOP_R     = 3'b000;
  localparam logic [2:0] ALUOP_BR    = 3'b001;
  localparam logic [2:0] ALUOP_ADD   = 3'b010;
  localparam logic [2:0] ALUOP_IALU  = 3'b011;
  localparam logic [2:0] ALUOP_UPPER = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I datapath: sequences each instruction
// and decodes all enables and mux selects from the current state.
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] ALUOp,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q, state_d;

  // Async reset lands in FETCH, so write strobes drop as soon as RST_n falls.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REGB;
    result_src = RES_ALUOUT;
    ALUOp      = ALUOP_R;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read   = 1'b1;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        ALUOp      = ALUOP_ADD;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        ALUOp     = ALUOP_ADD;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = ST_MEMADR;
          OP_RTYPE:          state_d = ST_EXECR;
          OP_ITYPE:          state_d = ST_EXECI;
          OP_BRANCH:         state_d = ST_BRANCH;
          OP_LUI, OP_AUIPC:  state_d = ST_UPPER;
          default:           state_d = ST_ERROR;
        endcase
      end
      ST_MEMADR: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
        ALUOp     = ALUOP_ADD;
        state_d   = (opcode == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
      end
      ST_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEMDATA;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_EXECR: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_REGB;
        ALUOp     = ALUOP_R;
        state_d   = ST_ALUWB;
      end
      ST_EXECI: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
        ALUOp     = ALUOP_IALU;
        state_d   = ST_ALUWB;
      end
      ST_UPPER: begin
        alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        ALUOp     = ALUOP_UPPER;
        state_d   = ST_ALUWB;
      end
      ST_ALUWB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_REGB;
        ALUOp      = ALUOP_BR;
        result_src = RES_ALUOUT;
        instr_done = 1'b1;
        pc_write   = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
        state_d    = ST_FETCH;
      end
      ST_ERROR: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle RV32I datapath: sequences fetch, decode, execute, memory and write-back for each instruction and drives all datapath enables and mux selects. Sits directly upstream of the ALU control decoder: produces the 3-bit `ALUOp` that decoder consumes, together with `{funct7[5], funct3}` taken from the instruction register. Supports R-type, I-type ALU, LW, SW, BEQ/BNE, LUI and AUIPC.

## Interface
- No parameters.
- `CLK` in 1: single clock, rising edge.
- `RST_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: IR[6:0], stable from DECODE until the instruction retires.
- `funct3` in 3: IR[14:12].
- `zero` in 1: ALU zero flag, combinational from the current ALU result.
- `mem_ready` in 1: memory accepts a write or returns read data in this cycle.
- `pc_write` out 1: PC load enable.
- `ir_write` out 1: instruction register and old-PC register load enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: ALU A select; 00 = PC, 01 = old PC, 10 = register A, 11 = constant 0.
- `alu_src_b` out 2: ALU B select; 00 = register B, 01 = immediate, 10 = constant 4.
- `result_src` out 2: result bus select; 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `ALUOp` out 3: 000 R, 001 branch, 010 load/store/add, 011 I-ALU, 100 LUI/AUIPC.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: unsupported opcode seen.
- `state` out 4: current state, for debug.

## Operation
- State register is reset to FETCH. States are FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, UPPER 10, ERROR 11.
- Outputs are decoded from the state; `pc_write`, `ir_write` and `instr_done` are additionally gated by the inputs as listed. Any output not listed for a state is 0 (selects and `ALUOp` are 0).
- **FETCH:** `mem_read`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `ALUOp`=010, `result_src`=10.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; otherwise go to DECODE.
- **DECODE:** `alu_src_a`=01, `alu_src_b`=01, `ALUOp`=010, computing oldPC+imm into ALUOut. Next state by opcode:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH.
  - 0110111 or 0010111 → UPPER.
  - Anything else → ERROR.
- **MEMADR:** `alu_src_a`=10, `alu_src_b`=01, `ALUOp`=010. Next is MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD:** `adr_src`=1, `mem_read`=1. Wait here for `mem_ready`, then go to MEMWB.
- **MEMWB:** `reg_write`=1, `result_src`=01, `instr_done`=1. Next is FETCH.
- **MEMWRITE:** `adr_src`=1, `mem_write`=1, `instr_done`=`mem_ready`. Wait for `mem_ready`, then go to FETCH.
- **EXECR:** `alu_src_a`=10, `alu_src_b`=00, `ALUOp`=000. Next is ALUWB.
- **EXECI:** `alu_src_a`=10, `alu_src_b`=01, `ALUOp`=011. Next is ALUWB.
- **UPPER:** `alu_src_b`=01, `ALUOp`=100. `alu_src_a` is 11 for LUI and 01 for AUIPC. Next is ALUWB.
- **ALUWB:** `reg_write`=1, `result_src`=00, `instr_done`=1. Next is FETCH.
- **BRANCH:** `alu_src_a`=10, `alu_src_b`=00, `ALUOp`=001, `result_src`=00, `instr_done`=1. Next is FETCH.
  - `pc_write` = (`funct3`==000 & `zero`) | (`funct3`==001 & !`zero`).
  - Any other `funct3` is never taken.
- **ERROR:** `illegal`=1 and all enables 0. Held until reset.

## Timing
- With `mem_ready` held at 1, cycles per instruction are:
  - LW: 5.
  - SW, R-type, I-type, LUI, AUIPC: 4.
  - BEQ/BNE: 3.
- Each `mem_ready`=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Reset values while `RST_n`=0 are the FETCH decode:
  - `mem_read`=1, `alu_src_b`=10, `ALUOp`=010, `result_src`=10, `state`=0.
  - `pc_write`=`ir_write`=`mem_ready`.
  - All other outputs 0.
- The datapath holds PC/IR in reset, so `pc_write` during reset is harmless.
- Reset asserted mid-instruction drops `mem_write` and `reg_write` immediately, without waiting for a clock edge. The first rising edge after release begins a fresh fetch.
- `instr_done` fires exactly once per retired instruction and never in ERROR.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - `state_t` enum (4-bit, encodings above).
  - Opcode constants.
  - `ALUOp` constants.
  - Mux-select constants for `alu_src_a`, `alu_src_b` and `result_src`, shared with the datapath and ALU control.
- Single module: one `always_ff` for the state register and one `always_comb` for next state and outputs. No sub-module.

## Test plan
- **R-type ADD** (opcode 0110011), `mem_ready`=1 → states 0,1,6,8,0; `ALUOp`=000 in EXECR; `reg_write`=1 only in ALUWB; `instr_done` pulses at cycle 4.
- **LW with 2 wait cycles in MEMREAD** → sequence 0,1,2,3,3,3,4; `adr_src`=1 throughout MEMREAD; `result_src`=01 with `reg_write`=1 in MEMWB.
- **BEQ and BNE:**
  - BEQ with `zero`=1 → `pc_write`=1 in BRANCH.
  - BEQ with `zero`=0 → `pc_write`=0.
  - BNE inverts both cases.
  - `funct3`=100 → never taken.
- **LUI and AUIPC** → UPPER with `alu_src_a`=11 and 01 respectively, `ALUOp`=100, then ALUWB.
- **Opcode 1110011** → ERROR after DECODE; `illegal`=1, no enables asserted for 10 cycles, `RST_n` pulse returns `state` to 0.
- **`RST_n` dropped during MEMWRITE** with `mem_ready`=0 → `mem_write` falls before the next edge and `state`=0.
